dm_block_mover: RTL and testbench
=================================

// Module: dm_block_mover
// PURPOSE
//  Bus initiator that drives the 32x8 data memory port (rd, wr, abus, in_dbus; reads out_dbus).
//  Executes block COPY (src->dst) and FILL (constant->dst) jobs of 0..32 bytes.
//  Sits between the control unit and the data memory. Owns the memory port while busy.
//  Guarantees the memory timing rules: abus and wdata are stable while wr=1, and rd is held for 2 cycles.
// PARAMETERS
//  AW  5  memory address width; memory depth is 2**AW
//  DW  8  data width
// PORTS
//  clk        in   1     clock; all state changes on rising edge
//  rst        in   1     synchronous reset, active-high
//  start      in   1     job request, sampled only in IDLE
//  op         in   1     0=COPY, 1=FILL; sampled with start
//  src        in   AW    COPY source base address
//  dst        in   AW    destination base address
//  len        in   AW+1  byte count, 0..2**AW
//  fill_val   in   DW    FILL data
//  busy       out  1     high from cycle after accepted start through DONE
//  done       out  1     one-cycle pulse when the job completes
//  mem_rd     out  1     to memory rd
//  mem_wr     out  1     to memory wr
//  mem_abus   out  AW    to memory abus
//  mem_wdata  out  DW    to memory in_dbus
//  mem_rdata  in   DW    from memory out_dbus
//  csum       out  DW    present only with DM_MOVER_CSUM_EN
// BEHAVIOUR
//  - All outputs registered. Reset values: busy=0, done=0, mem_rd=0, mem_wr=0,
//    mem_abus=0, mem_wdata=0, csum=0. Reset forces IDLE.
//  - Reset during a job: the job is abandoned and the strobes drop at that edge.
//  - FSM states: IDLE, RD, RD_CAP, WR, WR_REL, DONE.
//  - IDLE, start=1: latch op/src/dst/len/fill_val and clear the index i.
//    - len==0 -> DONE, with no memory access.
//    - COPY -> RD.  FILL -> WR.
//  - RD: mem_rd=1, mem_abus=src+i. Next state RD_CAP.
//  - RD_CAP: mem_rd=1 with the same address. Capture mem_rdata into buf at the end of the cycle. Next state WR.
//  - WR: mem_wr=1, mem_abus=dst+i, mem_wdata = buf (COPY) or fill_val (FILL). Next state WR_REL.
//  - WR_REL: mem_wr=0. Address and data held unchanged (the memory write is level-sensitive). i increments.
//    - i+1==len -> DONE.
//    - otherwise -> RD (COPY) or WR (FILL).
//  - DONE: done=1 for exactly one cycle, busy=1, then IDLE with busy=0.
//  - mem_rd and mem_wr are never high in the same cycle. Both are 0 in IDLE and DONE.
//  - Address arithmetic is mod 2**AW: src+i and dst+i wrap from 31 to 0. No error is raised.
//  - start while busy is ignored; no queueing. start in the DONE cycle is ignored.
//  - Overlapping COPY regions are copied in ascending order, byte by byte.
//    If dst>src and the regions overlap, data is replicated. This is the specified behaviour.
//  - Latency from the start-sampling edge to the done=1 cycle:
//    COPY 4*len+1 cycles, FILL 2*len+1 cycles, len=0 gives 1 cycle.
// CONFIGURATION
//  DM_MOVER_CSUM_EN defined:
//    - csum port exists. Cleared on an accepted start.
//    - Adds every byte written (mod 2**DW) at the WR edge.
//    - Valid and stable from the done pulse until the next accepted start.
//  DM_MOVER_CSUM_EN undefined: no csum port, no adder logic. All other behaviour is identical.
// TESTING
//  1. Memory 0..4 = 01..05. COPY src=0 dst=8 len=3
//     -> mem[8..10]=01,02,03; done at cycle 13 after start; csum=06.
//  2. FILL dst=30 len=4 fill=AA -> mem[30],[31],[0],[1]=AA (wrap); done at cycle 9; csum=A8.
//  3. len=0 COPY -> done at cycle 1; mem_rd and mem_wr never asserted; memory unchanged.
//  4. COPY src=0 dst=1 len=3 on 01,02,03 (overlap) -> mem[1..3]=01,01,01.
//  5. Pulse start again mid-job -> it is ignored; the first job completes unchanged.
//  6. Assert rst during WR -> next cycle: mem_wr=0, busy=0, IDLE.
//     Then a new FILL runs correctly.
//  All runs: monitor asserts mem_abus and mem_wdata never change while mem_wr=1,
//  and mem_rd and mem_wr are never both 1.

Source files
------------

// File: rtl/dm_block_mover.sv
// Block COPY/FILL engine that owns the 32x8 data memory port while a job runs.
// Define DM_MOVER_CSUM_EN to add the csum output (byte sum of everything written).
module dm_block_mover #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_abus,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DM_MOVER_CSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StRdCap,
    StWr,
    StWrRel,
    StDone
  } state_e;

  state_e        state;
  logic          op_q;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW:0]   len_q;
  logic [DW-1:0] fill_q;
  logic [AW:0]   idx_q;
  logic [AW:0]   idx_inc;

  // One bit wider than an address so that i+1 can reach a full-memory length.
  assign idx_inc = idx_q + {{AW{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_abus  <= '0;
      mem_wdata <= '0;
      op_q      <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      fill_q    <= '0;
      idx_q     <= '0;
`ifdef DM_MOVER_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            op_q   <= op;
            src_q  <= src;
            dst_q  <= dst;
            len_q  <= len;
            fill_q <= fill_val;
            idx_q  <= '0;
            busy   <= 1'b1;
`ifdef DM_MOVER_CSUM_EN
            csum   <= '0;
`endif
            if (len == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else if (op) begin
              state     <= StWr;
              mem_wr    <= 1'b1;
              mem_abus  <= dst;
              mem_wdata <= fill_val;
            end else begin
              state    <= StRd;
              mem_rd   <= 1'b1;
              mem_abus <= src;
            end
          end
        end
        StRd: begin
          state <= StRdCap;
        end
        StRdCap: begin
          // mem_wdata doubles as the read-capture buffer for COPY.
          state     <= StWr;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b1;
          mem_abus  <= dst_q + idx_q[AW-1:0];
          mem_wdata <= mem_rdata;
        end
        StWr: begin
          state  <= StWrRel;
          mem_wr <= 1'b0;
`ifdef DM_MOVER_CSUM_EN
          csum   <= csum + mem_wdata;
`endif
        end
        StWrRel: begin
          idx_q <= idx_inc;
          if (idx_inc == len_q) begin
            state <= StDone;
            done  <= 1'b1;
          end else if (op_q) begin
            state     <= StWr;
            mem_wr    <= 1'b1;
            mem_abus  <= dst_q + idx_inc[AW-1:0];
            mem_wdata <= fill_q;
          end else begin
            state    <= StRd;
            mem_rd   <= 1'b1;
            mem_abus <= src_q + idx_inc[AW-1:0];
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state  <= StIdle;
          busy   <= 1'b0;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_block_mover.sv
// Bench for dm_block_mover: a transaction-level job model predicts every bus cycle,
// the final memory image, latency and (with DM_MOVER_CSUM_EN) the checksum.
module tb_dm_block_mover;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd;
    logic       wr;
    logic       ca;
    logic [4:0] a;
    logic       cd;
    logic [7:0] d;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       op;
  logic [4:0] src;
  logic [4:0] dst;
  logic [5:0] len;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;
  logic       mem_rd;
  logic       mem_wr;
  logic [4:0] mem_abus;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef DM_MOVER_CSUM_EN
  logic [7:0] csum;
`endif

  logic [7:0] mem     [32];
  logic [7:0] ref_mem [32];
  logic [7:0] ld_img  [32];
  logic [7:0] snap    [32];
  logic       ld_we;
  bit         chk_en;
  cyc_t       exp_q   [$];
  cyc_t       pend_q  [$];
  logic [7:0] exp_csum;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  dm_block_mover #(
    .AW (5),
    .DW (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill_val  (fill_val),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_abus  (mem_abus),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DM_MOVER_CSUM_EN
    ,
    .csum      (csum)
`endif
  );

  // 32x8 data memory: level write sampled at the edge, combinational read.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_abus] <= mem_wdata;
    else if (ld_we) mem <= ld_img;
  end
  always_comb mem_rdata = mem_rd ? mem[mem_abus] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = -1;
    for (int k = 0; k < 32; k++) if (mem[k] !== ref_mem[k] && bad < 0) bad = k;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: mem[%0d] got %h, want %h", name, bad, mem[bad], ref_mem[bad]);
    end
  endtask

  function automatic cyc_t mk(input logic b, input logic dn, input logic r, input logic w,
                              input logic ca, input logic [4:0] a, input logic cd,
                              input logic [7:0] d);
    cyc_t c;
    c.busy = b; c.done = dn; c.rd = r; c.wr = w; c.ca = ca; c.a = a; c.cd = cd; c.d = d;
    return c;
  endfunction

  // Expand one job into its expected bus cycles, applying the writes to ref_mem in order.
  task automatic plan_job(input logic fop, input logic [4:0] s, input logic [4:0] d,
                          input logic [5:0] n, input logic [7:0] f);
    logic [4:0] sa, da;
    logic [7:0] v;
    pend_q.delete();
    exp_csum = 8'h00;
    for (int k = 0; k < int'(n); k++) begin
      sa = s + 5'(k);
      da = d + 5'(k);
      v  = fop ? f : ref_mem[sa];
      if (!fop) begin
        pend_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, sa, 1'b0, 8'h00));
        pend_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, sa, 1'b0, 8'h00));
      end
      pend_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, da, 1'b1, v));
      pend_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, da, 1'b1, v));
      ref_mem[da] = v;
      exp_csum    = exp_csum + v;
    end
    pend_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00));
  endtask

  task automatic run_job(input logic fop, input logic [4:0] s, input logic [4:0] d,
                         input logic [5:0] n, input logic [7:0] f, input int poke,
                         input bit poke_done, output int lat);
    int exp_lat;
    exp_lat = (n == 6'd0) ? 1 : (fop ? 2 * int'(n) + 1 : 4 * int'(n) + 1);
    plan_job(fop, s, d, n, f);
    @(posedge clk); #1;
    start = 1'b1; op = fop; src = s; dst = d; len = n; fill_val = f;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q = pend_q;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == poke + 1) start = 1'b0;
      if (lat == poke) begin
        start    = 1'b1;
        op       = 1'($urandom_range(0, 1));
        src      = 5'($urandom);
        dst      = 5'($urandom);
        len      = 6'($urandom_range(1, 32));
        fill_val = 8'($urandom);
      end
      if (done === 1'b1 || lat >= 200) break;
    end
    check("latency", lat, exp_lat);
    if (done !== 1'b1) exp_q.delete();
`ifdef DM_MOVER_CSUM_EN
    check("csum_at_done", {24'd0, csum}, {24'd0, exp_csum});
`endif
    if (poke_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef DM_MOVER_CSUM_EN
    check("csum_hold", {24'd0, csum}, {24'd0, exp_csum});
`endif
    check_mem("mem_image");
  endtask

  task automatic load_mem();
    ref_mem = ld_img;
    @(posedge clk); #1;
    ld_we = 1'b1;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  // Per-cycle compare against the planned bus cycles, plus the write-hold and strobe monitors.
  initial begin : cmp
    cyc_t       r;
    logic       pw, re;
    logic [4:0] pa;
    logic [7:0] pd;
    pw = 1'b0; pa = '0; pd = '0;
    forever begin
      @(posedge clk);
      re = rst;
      @(negedge clk);
      if (pw && !re) begin
        check("wr_hold_abus", {27'd0, mem_abus}, {27'd0, pa});
        check("wr_hold_wdata", {24'd0, mem_wdata}, {24'd0, pd});
      end
      pw = mem_wr; pa = mem_abus; pd = mem_wdata;
      check("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
      if (chk_en) begin
        r = (exp_q.size() > 0) ? exp_q.pop_front() : mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,
                                                         1'b0, 8'h00);
        check("bus_cycle",
              {15'd0, busy, done, mem_rd, mem_wr, r.ca ? mem_abus : 5'd0,
               r.cd ? mem_wdata : 8'h00},
              {15'd0, r.busy, r.done, r.rd, r.wr, r.a, r.d});
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         lat;
    logic       fop;
    logic [5:0] n;
    int         max_lat;
    int         poke;
    rst = 1'b1; start = 1'b0; op = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
    ld_we = 1'b0; chk_en = 1'b0;
    for (int k = 0; k < 32; k++) ld_img[k] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rd_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
    check("rst_abus", {27'd0, mem_abus}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
`ifdef DM_MOVER_CSUM_EN
    check("rst_csum", {24'd0, csum}, 32'd0);
`endif
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic COPY.
    for (int k = 0; k < 5; k++) ld_img[k] = 8'(k + 1);
    load_mem();
    run_job(1'b0, 5'd0, 5'd8, 6'd3, 8'h00, 0, 1'b0, lat);
    check("t1_latency", lat, 13);
    check("t1_mem8", {24'd0, mem[8]}, 32'h01);
    check("t1_mem9", {24'd0, mem[9]}, 32'h02);
    check("t1_mem10", {24'd0, mem[10]}, 32'h03);
`ifdef DM_MOVER_CSUM_EN
    check("t1_csum", {24'd0, csum}, 32'h06);
`endif

    // FILL wrapping past the top of memory.
    run_job(1'b1, 5'd0, 5'd30, 6'd4, 8'hAA, 0, 1'b0, lat);
    check("t2_latency", lat, 9);
    check("t2_mem30", {24'd0, mem[30]}, 32'hAA);
    check("t2_mem31", {24'd0, mem[31]}, 32'hAA);
    check("t2_mem0", {24'd0, mem[0]}, 32'hAA);
    check("t2_mem1", {24'd0, mem[1]}, 32'hAA);
`ifdef DM_MOVER_CSUM_EN
    check("t2_csum", {24'd0, csum}, 32'hA8);
`endif

    // Zero-length job touches nothing.
    snap = mem;
    run_job(1'b0, 5'd3, 5'd7, 6'd0, 8'h55, 0, 1'b0, lat);
    check("t3_latency", lat, 1);
    begin
      int diff = 0;
      for (int k = 0; k < 32; k++) if (mem[k] !== snap[k]) diff++;
      check("t3_mem_unchanged", diff, 0);
    end

    // Overlapping ascending COPY replicates the first byte.
    for (int k = 0; k < 32; k++) ld_img[k] = (k < 3) ? 8'(k + 1) : 8'h00;
    load_mem();
    run_job(1'b0, 5'd0, 5'd1, 6'd3, 8'h00, 0, 1'b0, lat);
    check("t4_mem1", {24'd0, mem[1]}, 32'h01);
    check("t4_mem2", {24'd0, mem[2]}, 32'h01);
    check("t4_mem3", {24'd0, mem[3]}, 32'h01);

    // start pulses mid-job and in the DONE cycle are ignored.
    for (int k = 0; k < 32; k++) ld_img[k] = 8'(8'h40 + k);
    load_mem();
    run_job(1'b0, 5'd4, 5'd12, 6'd5, 8'h00, 3, 1'b1, lat);
    check("t5_latency", lat, 21);
    check("t5_mem12", {24'd0, mem[12]}, 32'h44);
    check("t5_mem16", {24'd0, mem[16]}, 32'h48);

    // Reset while a FILL is in its write cycle.
    chk_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 1'b1; dst = 5'd20; len = 6'd5; fill_val = 8'h5C;
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_in_wr", {30'd0, mem_wr, busy}, 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_after_rst", {28'd0, busy, done, mem_rd, mem_wr}, 32'd0);
    rst = 1'b0;
    ref_mem[20] = 8'h5C;
    @(posedge clk); #1;
    check("t6_stays_idle", {31'd0, busy}, 32'd0);
    chk_en = 1'b1;
    run_job(1'b1, 5'd0, 5'd2, 6'd6, 8'h3C, 0, 1'b0, lat);
    check("t6_latency", lat, 13);
    check("t6_mem2", {24'd0, mem[2]}, 32'h3C);
    check("t6_mem7", {24'd0, mem[7]}, 32'h3C);
    check("t6_mem20", {24'd0, mem[20]}, 32'h5C);

    // Randomized jobs against the model.
    for (int k = 0; k < 32; k++) ld_img[k] = 8'($urandom);
    load_mem();
    for (int j = 0; j < 40; j++) begin
      fop = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 32)) : 6'($urandom_range(0, 6));
      max_lat = (n == 6'd0) ? 1 : (fop ? 2 * int'(n) + 1 : 4 * int'(n) + 1);
      poke = (max_lat > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, max_lat - 1)) : 0;
      run_job(fop, 5'($urandom), 5'($urandom), n, 8'($urandom), poke,
              1'($urandom_range(0, 1)), lat);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
